// File: rtl/tx_ser_pkg.sv
// tx_ser_pkg: serializer FSM state type and default parameter values
package tx_ser_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STUFF} tx_state_t;
  localparam int DEF_NUM_BITS = 8;
  localparam bit DEF_SHIFT_MSB = 1'b1;
  localparam logic DEF_IDLE_VAL = 1'b1;
  localparam bit DEF_STUFF_EN = 1'b1;
  localparam int DEF_STUFF_LEN = 6;
endpackage

// File: rtl/tx_bit_counter.sv
// tx_bit_counter: W-bit counter; in clk rst clr en, out cnt at_max (cnt == MAX, wraps to 0 on en)
module tx_bit_counter #(
  parameter int W = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  assign at_max = cnt == W'(MAX);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= at_max ? '0 : cnt + W'(1);
endmodule

// File: rtl/tx_serializer.sv
// tx_serializer: bit-stuffing parallel-to-serial shifter; in clk rst shift_enable data_in data_valid, out data_ready serial_out busy word_done
module tx_serializer
  import tx_ser_pkg::*;
#(
  parameter int   NUM_BITS  = DEF_NUM_BITS,
  parameter bit   SHIFT_MSB = DEF_SHIFT_MSB,
  parameter logic IDLE_VAL  = DEF_IDLE_VAL,
  parameter bit   STUFF_EN  = DEF_STUFF_EN,
  parameter int   STUFF_LEN = DEF_STUFF_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                word_done
);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  tx_state_t state, state_n;
  logic [NUM_BITS-1:0] sr, sr_n, hold, shifted;
  logic [BW-1:0] bit_cnt;
  logic [OW-1:0] ones_cnt;
  logic hold_full, out_bit, consume, last, stuff_hit, word_end, load, bit_max, ones_full, so_n;
  assign hold_full = ~data_ready;
  assign out_bit   = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];
  assign shifted   = SHIFT_MSB ? {sr[NUM_BITS-2:0], IDLE_VAL} : {IDLE_VAL, sr[NUM_BITS-1:1]};
  assign consume   = state == SHIFT && shift_enable;
  assign last      = bit_cnt == BW'(NUM_BITS - 1);
  assign stuff_hit = STUFF_EN && out_bit && ones_cnt == OW'(STUFF_LEN - 1);
  // a word finishes on its last data bit, or on the stuff bit that trails it (bit_cnt already at NUM_BITS)
  assign word_end  = (consume && last && !stuff_hit) || (state == STUFF && shift_enable && bit_max);
  assign load      = state == LOAD || (word_end && hold_full);
  assign word_done = !rst && consume && last;
  always_comb begin
    state_n = state;
    sr_n = sr;
    case (state)
      IDLE:    state_n = hold_full ? LOAD : IDLE;
      LOAD:    begin sr_n = hold; state_n = SHIFT; end
      SHIFT:   if (consume) begin sr_n = shifted; state_n = stuff_hit ? STUFF : SHIFT; end
      STUFF:   state_n = shift_enable ? SHIFT : STUFF;
      default: state_n = IDLE;
    endcase
    if (word_end) begin
      state_n = hold_full ? SHIFT : IDLE;
      sr_n = hold_full ? hold : sr_n;
    end
  end
  assign so_n = state_n == SHIFT ? (SHIFT_MSB ? sr_n[NUM_BITS-1] : sr_n[0]) : state_n == STUFF ? 1'b0 : IDLE_VAL;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sr <= {NUM_BITS{IDLE_VAL}};
      hold <= '0;
      data_ready <= 1'b1;
      serial_out <= IDLE_VAL;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      serial_out <= so_n;
      busy <= state_n != IDLE;
      if (data_valid && data_ready) begin
        hold <= data_in;
        data_ready <= 1'b0;
      end else if (load) data_ready <= 1'b1;
    end
  tx_bit_counter #(.W(BW), .MAX(NUM_BITS)) u_bit_cnt (
    .clk(clk), .rst(rst), .clr(load), .en(consume), .cnt(bit_cnt), .at_max(bit_max)
  );
  // ones_full only holds in STUFF, so its strobe is the stuff bit being sent
  tx_bit_counter #(.W(OW), .MAX(STUFF_LEN)) u_ones_cnt (
    .clk(clk), .rst(rst),
    .clr(!STUFF_EN || (ones_full && shift_enable) || (consume && !out_bit) || (word_end && !hold_full)),
    .en(STUFF_EN && consume && out_bit), .cnt(ones_cnt), .at_max(ones_full)
  );
endmodule
